// File: rtl/mult_pkg.sv
// Shared types and defaults for the serial shift-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int unsigned WIDTH = 4;
endpackage

// File: rtl/prod_add.sv
// N-bit unsigned adder with carry out, used for the partial-product step.
module prod_add #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N:0]   sum
);
    assign sum = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/prod_acc.sv
// Serial shift-add multiplier: N-bit multiplicand times a multiplier
// streamed LSB first, accumulating into a 2N-bit product.
module prod_acc
    import mult_pkg::*;
#(
    parameter int unsigned N = WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic           bit_in,
    input  logic           bit_valid,
    output logic           shift_req,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int unsigned CW = $clog2(N + 1);

    state_t         state;
    logic [N-1:0]   a_lat;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum;

    prod_add #(.N(N)) u_add (
        .x   (acc[2*N-1:N]),
        .y   (a_lat),
        .sum (sum)
    );

    assign product = acc;

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_lat     <= '0;
            acc       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            shift_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_lat     <= a;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        shift_req <= 1'b1;
                    end
                end
                RUN: begin
                    if (bit_valid) begin
                        if (bit_in)
                            acc <= {sum, acc[N-1:1]};
                        else
                            acc <= {1'b0, acc[2*N-1:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N - 1)) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            shift_req <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    shift_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prod_acc.sv
// Directed and randomized checks of the serial multiplier against a*B.
module tb_prod_acc;
    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst, start, bit_in, bit_valid;
    logic [N-1:0] a;
    logic         shift_req, busy, done;
    logic [2*N-1:0] product;

    int checks = 0;
    int errors = 0;

    prod_acc #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .shift_req (shift_req),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs driven and outputs sampled on the falling edge.
    task automatic run_mult(input string tag, input logic [3:0] av, input logic [3:0] bv,
                            input int stall_at, input int stall_len, input bit rand_gaps,
                            input bit mid_start, input bit end_poke);
        int cyc;
        int g;
        int gsum;
        logic [15:0] exp;
        exp  = 16'(av) * 16'(bv);
        cyc  = 0;
        gsum = 0;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        cyc++;
        check({tag, ":busy_run"}, 16'(busy), 16'd1);
        check({tag, ":shreq_run"}, 16'(shift_req), 16'd1);
        for (int i = 0; i < int'(N); i++) begin
            g = rand_gaps ? int'($urandom_range(0, 2)) : ((i == stall_at) ? stall_len : 0);
            gsum += g;
            repeat (g) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                @(negedge clk);
                cyc++;
                check({tag, ":shreq_stall"}, 16'(shift_req), 16'd1);
                check({tag, ":done_stall"}, 16'(done), 16'd0);
            end
            bit_valid = 1'b1;
            bit_in    = bv[i];
            if (mid_start && i == 1) begin
                start = 1'b1;
                a     = 4'd1;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (i < int'(N) - 1) begin
                check({tag, ":done_early"}, 16'(done), 16'd0);
                check({tag, ":shreq_bit"}, 16'(shift_req), 16'd1);
            end
        end
        check({tag, ":done"}, 16'(done), 16'd1);
        check({tag, ":latency"}, 16'(cyc + 1), 16'(int'(N) + 2 + gsum));
        check({tag, ":product"}, 16'(product), exp);
        check({tag, ":shreq_done"}, 16'(shift_req), 16'd0);
        check({tag, ":busy_done"}, 16'(busy), 16'd1);
        start     = end_poke;
        bit_valid = end_poke;
        bit_in    = 1'b1;
        a         = 4'd3;
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b0;
        check({tag, ":done_width"}, 16'(done), 16'd0);
        check({tag, ":busy_idle"}, 16'(busy), 16'd0);
        check({tag, ":product_hold"}, 16'(product), exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; a = '0;
        repeat (3) @(negedge clk);
        check("rst:product", 16'(product), 16'd0);
        check("rst:busy", 16'(busy), 16'd0);
        check("rst:done", 16'(done), 16'd0);
        check("rst:shreq", 16'(shift_req), 16'd0);
        rst = 1'b0;

        // Idle ignores serial bits.
        bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        check("idle:product", 16'(product), 16'd0);
        check("idle:busy", 16'(busy), 16'd0);

        run_mult("basic", 4'd13, 4'd11, -1, 0, 1'b0, 1'b0, 1'b0);
        run_mult("max", 4'd15, 4'd15, -1, 0, 1'b0, 1'b0, 1'b0);
        run_mult("a0", 4'd0, 4'd15, -1, 0, 1'b0, 1'b0, 1'b0);
        run_mult("b0", 4'd15, 4'd0, -1, 0, 1'b0, 1'b0, 1'b0);
        run_mult("stall", 4'd7, 4'd6, 2, 3, 1'b0, 1'b0, 1'b0);
        run_mult("busy_start", 4'd13, 4'd11, -1, 0, 1'b0, 1'b1, 1'b1);

        // Reset after two consumed bits aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; a = 4'd9;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_in = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        check("abort:busy", 16'(busy), 16'd0);
        check("abort:product", 16'(product), 16'd0);
        check("abort:done", 16'(done), 16'd0);
        check("abort:shreq", 16'(shift_req), 16'd0);
        @(negedge clk);
        check("abort:done2", 16'(done), 16'd0);
        check("abort:busy2", 16'(busy), 16'd0);
        run_mult("after_abort", 4'd9, 4'd7, -1, 0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 200; k++)
            run_mult("rand", 4'($urandom), 4'($urandom), -1, 0, 1'b1, 1'b0, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prod_acc.md
PROD_ACC -- requirements
Module: prod_acc

Interface
REQ-001 SHALL have parameter: N, 4, operand width in bits (multiplicand width and serial multiplier bit count).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a multiplication.
REQ-005 SHALL have port: a  input  N  multiplicand, sampled only on an accepted start.
REQ-006 SHALL have port: bit_in  input  1  serial multiplier bit, LSB first.
REQ-007 SHALL have port: bit_valid  input  1  qualifies bit_in in the current cycle.
REQ-008 SHALL have port: shift_req  output  1  request to the serial source to present the next bit.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when product is final.
REQ-011 SHALL have port: product  output  2N  accumulated result; holds its value between operations.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 SHALL latch a, clear the accumulator to 0, clear the bit counter to 0, and go to RUN on the next edge.
REQ-014 IDLE: bit_valid SHALL be ignored, and the accumulator SHALL hold.
REQ-015 RUN: shift_req SHALL be 1 while fewer than N bits have been consumed, and 0 in all other states.
REQ-016 RUN, bit_valid=1, bit_in=1: sum = acc[2N-1:N] + a_latched (N+1 bits); acc SHALL become {sum, acc[N-1:1]}.
REQ-017 RUN, bit_valid=1, bit_in=0: acc SHALL become {1'b0, acc[2N-1:1]}.
REQ-018 RUN, bit_valid=0: acc and the counter SHALL hold (stall); no timeout.
REQ-019 The counter SHALL increment on each valid bit; the Nth valid bit SHALL move the FSM to DONE.
REQ-020 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-021 product SHALL equal acc at all times; after DONE it SHALL equal a*B exactly (2N bits, no overflow possible).
REQ-022 start while busy=1 SHALL be ignored, with no effect on a_latched, acc or counter.
REQ-023 bit_valid in DONE SHALL be ignored.
REQ-024 start in the same cycle as done SHALL be ignored; a new start is accepted from IDLE only.
REQ-025 Latency SHALL be 1 (start->RUN) + N valid-bit cycles + 1 (DONE); this is N+2 cycles with no stalls.

Reset
REQ-026 rst=1 SHALL force state=IDLE, acc=0, counter=0, a_latched=0, done=0, busy=0, shift_req=0 on the next edge, from any state.
REQ-027 rst SHALL override start and bit_valid in the same cycle.
REQ-028 Reset mid-RUN SHALL abort without a done pulse and leave product=0.

Structure
REQ-029 Package mult_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default operand width constant (4).
REQ-030 The counter width SHALL be $clog2(N+1) bits, derived in the module.
REQ-031 One sub-module is natural: prod_add, an N-bit adder producing an N+1-bit sum; prod_acc SHALL instantiate it once.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Verification
REQ-033 Basic: a=4'd13, serial B=4'd11 (bits 1,1,0,1), bit_valid continuous -> done at cycle 6 after start, product=8'd143.
REQ-034 Max: a=4'd15, B=4'd15 -> product=8'd225; a=0, B=15 -> product=0; a=15, B=0 -> product=0.
REQ-035 Stall: B=4'd6 with bit_valid low for 3 cycles between bits 2 and 3 -> product=8'd(a*6), done delayed by exactly 3 cycles, shift_req high throughout RUN.
REQ-036 Busy start: a second start with a=4'd1 mid-RUN -> ignored; result uses the first a.
REQ-037 Reset: rst pulsed after 2 valid bits -> next cycle busy=0, product=0, no done pulse; a fresh start then completes correctly.
REQ-038 Random: 200 random (a,B) pairs with random bit_valid gaps -> product==a*B on every done, and done width always 1 cycle.
